// File: rtl/lsu_pkg.sv
// Shared LSU definitions: address geometry, access sizes, fault codes,
// scheduler states and requester ids.
package lsu_pkg;

  localparam int unsigned VA_W     = 32;
  localparam int unsigned PG_OFF_W = 12;
  localparam int unsigned VPN_W    = VA_W - PG_OFF_W;

  typedef enum logic [1:0] {
    SZ_1B = 2'b00,
    SZ_2B = 2'b01,
    SZ_4B = 2'b10,
    SZ_8B = 2'b11
  } size_e;

  typedef logic [1:0] fault_t;

  localparam fault_t FLT_NONE = 2'b00;
  localparam fault_t FLT_MISS = 2'b01;
  localparam fault_t FLT_NP   = 2'b10;
  localparam fault_t FLT_WP   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOOK0 = 2'b01,
    ST_LOOK1 = 2'b10,
    ST_DONE  = 2'b11
  } sched_state_e;

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } req_id_e;

  // Access size encoding to (byte count - 1), i.e. offset of the last byte.
  function automatic logic [2:0] size_bytes_m1(input logic [1:0] size);
    logic [2:0] r;
    case (size)
      SZ_1B:   r = 3'd0;
      SZ_2B:   r = 3'd1;
      SZ_4B:   r = 3'd3;
      default: r = 3'd7;
    endcase
    return r;
  endfunction

  // Fault priority: miss, then not-present, then write to a read-only page.
  function automatic fault_t fault_code(input logic hit, input logic pre,
                                        input logic rw, input logic is_store);
    fault_t f;
    if (!hit)                f = FLT_MISS;
    else if (!pre)           f = FLT_NP;
    else if (is_store && !rw) f = FLT_WP;
    else                     f = FLT_NONE;
    return f;
  endfunction

endpackage

// File: rtl/dtlb_lookup_sched_if.sv
// Requester, result and DTLB-port signals of the lookup scheduler.
interface dtlb_lookup_sched_if;
  import lsu_pkg::*;

  logic               rd_v;
  logic [VA_W-1:0]    rd_addr;
  logic [1:0]         rd_size;
  logic               wr_v;
  logic [VA_W-1:0]    wr_addr;
  logic [1:0]         wr_size;

  logic               rd_stall;
  logic               wr_stall;
  logic               rd_done;
  logic               wr_done;
  logic [VA_W-1:0]    pa_lo;
  logic [VA_W-1:0]    pa_hi;
  logic               split;
  logic               pcd;
  logic [1:0]         fault;

  logic               tlb_lookup;
  logic [VPN_W-1:0]   tlb_vpn;
  logic               tlb_hit;
  logic [VPN_W-1:0]   tlb_rpn;
  logic               tlb_pre;
  logic               tlb_rw;
  logic               tlb_pcd;

  modport slave (
    input  rd_v, rd_addr, rd_size, wr_v, wr_addr, wr_size,
    input  tlb_hit, tlb_rpn, tlb_pre, tlb_rw, tlb_pcd,
    output rd_stall, wr_stall, rd_done, wr_done,
    output pa_lo, pa_hi, split, pcd, fault,
    output tlb_lookup, tlb_vpn
  );

  modport master (
    output rd_v, rd_addr, rd_size, wr_v, wr_addr, wr_size,
    output tlb_hit, tlb_rpn, tlb_pre, tlb_rw, tlb_pcd,
    input  rd_stall, wr_stall, rd_done, wr_done,
    input  pa_lo, pa_hi, split, pcd, fault,
    input  tlb_lookup, tlb_vpn
  );

endinterface

// File: rtl/tlb_page_split.sv
// Detects whether an access starting at a page offset runs past the 4 KB page.
module tlb_page_split
  import lsu_pkg::*;
(
  input  logic [PG_OFF_W-1:0] page_off,
  input  logic [1:0]          size,
  output logic                split
);

  logic [PG_OFF_W:0] end_off;

  // Last-byte offset on a one-bit-wider sum; the carry means a page crossing.
  always_comb begin
    end_off = {1'b0, page_off} + {{(PG_OFF_W - 2){1'b0}}, size_bytes_m1(size)};
    split   = end_off[PG_OFF_W];
  end

endmodule

// File: rtl/dtlb_lookup_sched.sv
// Arbitrates load/store requesters onto the single DTLB lookup port,
// splitting page-crossing accesses into two lookups.
module dtlb_lookup_sched
  import lsu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  dtlb_lookup_sched_if.slave  bus
);

  sched_state_e        state_q, state_d;
  req_id_e             last_grant_q, last_grant_d;
  req_id_e             id_q, id_d;
  logic [PG_OFF_W-1:0] off_q, off_d;
  logic                xsplit_q, xsplit_d;
  logic [VPN_W-1:0]    rpn0_q, rpn0_d;
  logic                pcd_acc_q, pcd_acc_d;
  logic                tlb_lookup_q, tlb_lookup_d;
  logic [VPN_W-1:0]    tlb_vpn_q, tlb_vpn_d;
  logic [VA_W-1:0]     pa_lo_q, pa_lo_d;
  logic [VA_W-1:0]     pa_hi_q, pa_hi_d;
  logic                split_q, split_d;
  logic                pcd_q, pcd_d;
  fault_t              fault_q, fault_d;
  logic                rd_done_q, rd_done_d;
  logic                wr_done_q, wr_done_d;

  logic                gnt_v;
  req_id_e             gnt_id;
  logic [VA_W-1:0]     sel_addr;
  logic [1:0]          sel_size;
  logic                sel_split;
  fault_t              look_fault;
  logic                look_pcd;

  // Round-robin pick between requesters; a lone requester always wins.
  always_comb begin
    gnt_v = bus.rd_v | bus.wr_v;
    if (bus.rd_v && bus.wr_v)
      gnt_id = (last_grant_q == REQ_WR) ? REQ_RD : REQ_WR;
    else if (bus.wr_v)
      gnt_id = REQ_WR;
    else
      gnt_id = REQ_RD;
    sel_addr = (gnt_id == REQ_WR) ? bus.wr_addr : bus.rd_addr;
    sel_size = (gnt_id == REQ_WR) ? bus.wr_size : bus.rd_size;
  end

  tlb_page_split u_split (
    .page_off (sel_addr[PG_OFF_W-1:0]),
    .size     (sel_size),
    .split    (sel_split)
  );

  // Classify the DTLB response for the page currently being looked up.
  always_comb begin
    look_fault = fault_code(bus.tlb_hit, bus.tlb_pre, bus.tlb_rw, id_q == REQ_WR);
    look_pcd   = bus.tlb_hit & bus.tlb_pcd;
  end

  // Next-state and next-output computation for the scheduler.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    off_d        = off_q;
    xsplit_d     = xsplit_q;
    rpn0_d       = rpn0_q;
    pcd_acc_d    = pcd_acc_q;
    tlb_lookup_d = 1'b0;
    tlb_vpn_d    = tlb_vpn_q;
    pa_lo_d      = pa_lo_q;
    pa_hi_d      = pa_hi_q;
    split_d      = split_q;
    pcd_d        = pcd_q;
    fault_d      = fault_q;
    rd_done_d    = 1'b0;
    wr_done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_v) begin
          last_grant_d = gnt_id;
          id_d         = gnt_id;
          off_d        = sel_addr[PG_OFF_W-1:0];
          xsplit_d     = sel_split;
          tlb_lookup_d = 1'b1;
          tlb_vpn_d    = sel_addr[VA_W-1:PG_OFF_W];
          state_d      = ST_LOOK0;
        end
      end

      ST_LOOK0: begin
        rpn0_d    = bus.tlb_rpn;
        pcd_acc_d = look_pcd;
        if (xsplit_q && (look_fault == FLT_NONE)) begin
          tlb_lookup_d = 1'b1;
          tlb_vpn_d    = tlb_vpn_q + 1'b1;
          state_d      = ST_LOOK1;
        end else begin
          // Single-lookup completion: publish straight from the DTLB response.
          pa_lo_d   = {bus.tlb_rpn, off_q};
          pa_hi_d   = '0;
          split_d   = xsplit_q;
          pcd_d     = look_pcd;
          fault_d   = look_fault;
          rd_done_d = (id_q == REQ_RD);
          wr_done_d = (id_q == REQ_WR);
          state_d   = ST_DONE;
        end
      end

      ST_LOOK1: begin
        pa_lo_d   = {rpn0_q, off_q};
        pa_hi_d   = {bus.tlb_rpn, {PG_OFF_W{1'b0}}};
        split_d   = 1'b1;
        pcd_d     = pcd_acc_q | look_pcd;
        fault_d   = look_fault;
        rd_done_d = (id_q == REQ_RD);
        wr_done_d = (id_q == REQ_WR);
        state_d   = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; async reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= REQ_WR;
      id_q         <= REQ_RD;
      off_q        <= '0;
      xsplit_q     <= 1'b0;
      rpn0_q       <= '0;
      pcd_acc_q    <= 1'b0;
      tlb_lookup_q <= 1'b0;
      tlb_vpn_q    <= '0;
      pa_lo_q      <= '0;
      pa_hi_q      <= '0;
      split_q      <= 1'b0;
      pcd_q        <= 1'b0;
      fault_q      <= FLT_NONE;
      rd_done_q    <= 1'b0;
      wr_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      off_q        <= off_d;
      xsplit_q     <= xsplit_d;
      rpn0_q       <= rpn0_d;
      pcd_acc_q    <= pcd_acc_d;
      tlb_lookup_q <= tlb_lookup_d;
      tlb_vpn_q    <= tlb_vpn_d;
      pa_lo_q      <= pa_lo_d;
      pa_hi_q      <= pa_hi_d;
      split_q      <= split_d;
      pcd_q        <= pcd_d;
      fault_q      <= fault_d;
      rd_done_q    <= rd_done_d;
      wr_done_q    <= wr_done_d;
    end
  end

  // Stalls are gated by reset so every output reads zero while it is held.
  assign bus.rd_stall   = rst & bus.rd_v & ~rd_done_q;
  assign bus.wr_stall   = rst & bus.wr_v & ~wr_done_q;
  assign bus.rd_done    = rd_done_q;
  assign bus.wr_done    = wr_done_q;
  assign bus.pa_lo      = pa_lo_q;
  assign bus.pa_hi      = pa_hi_q;
  assign bus.split      = split_q;
  assign bus.pcd        = pcd_q;
  assign bus.fault      = fault_q;
  assign bus.tlb_lookup = tlb_lookup_q;
  assign bus.tlb_vpn    = tlb_vpn_q;

endmodule
